// File: rtl/gpio_wb_responder.sv
// gpio_wb_responder
//   Wishbone classic responder giving the bus master register access to up
//   to 32 general-purpose pins: per-pin direction and output data, a
//   two-flop input synchronizer, and per-pin edge detection with sticky
//   write-1-to-clear status and a registered level interrupt.
//
// Ports:
//   clock     : Wishbone clock, all state changes on its rising edge
//   resetn    : synchronous active-low reset
//   wb_adr_i  : byte address, [4:2] selects the register
//   wb_dat_i  : write data
//   wb_sel_i  : byte enables
//   wb_we_i   : 1 = write
//   wb_cyc_i  : bus cycle
//   wb_stb_i  : strobe
//   wb_dat_o  : registered read data, valid with wb_ack_o
//   wb_ack_o  : one-cycle transfer acknowledge
//   gpio_i    : raw asynchronous pin inputs
//   gpio_o    : output data (OUT register)
//   gpio_oe   : per-pin output enable (DIR register)
//   irq_o     : level interrupt, |(STATUS & IRQ_EN) registered
module gpio_wb_responder #(
  parameter int          GPIO_WIDTH = 8,
  parameter logic [31:0] RESET_DIR  = 32'd0,
  parameter logic [31:0] RESET_OUT  = 32'd0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [4:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  localparam logic [2:0] A_IN      = 3'd0;
  localparam logic [2:0] A_OUT     = 3'd1;
  localparam logic [2:0] A_DIR     = 3'd2;
  localparam logic [2:0] A_RISE_EN = 3'd3;
  localparam logic [2:0] A_FALL_EN = 3'd4;
  localparam logic [2:0] A_STATUS  = 3'd5;
  localparam logic [2:0] A_IRQ_EN  = 3'd6;

  logic [0:0]            state_reg;
  logic                  ack_reg;
  logic [31:0]           dat_reg;
  logic                  irq_reg;
  logic [GPIO_WIDTH-1:0] out_reg, dir_reg, rise_en_reg, fall_en_reg;
  logic [GPIO_WIDTH-1:0] status_reg, irq_en_reg;
  logic [GPIO_WIDTH-1:0] sync1_reg, sync2_reg, prev_reg;

  logic [31:0]           byte_mask;
  logic [GPIO_WIDTH-1:0] wmask, wdata, w1c_mask, rise, fall, status_next;
  logic [31:0]           rdata;
  logic [2:0]            adr;
  logic                  req, wr;

  // Expand byte enables to a bit mask over the 32-bit data bus.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_mask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  assign adr   = wb_adr_i[4:2];
  assign wmask = byte_mask[GPIO_WIDTH-1:0];
  assign wdata = wb_dat_i[GPIO_WIDTH-1:0];

  // A new request is only accepted from IDLE; the ACK cycle always returns
  // to IDLE, so a held strobe is served every second cycle.
  assign req = wb_cyc_i & wb_stb_i & ~ack_reg & (state_reg == S_IDLE);
  assign wr  = req & wb_we_i;

  function automatic logic [GPIO_WIDTH-1:0] merge(
    input logic [GPIO_WIDTH-1:0] old_val,
    input logic [GPIO_WIDTH-1:0] new_val,
    input logic [GPIO_WIDTH-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // Edge detection compares the synchronized value against its delayed copy.
  assign rise     = sync2_reg & ~prev_reg & rise_en_reg;
  assign fall     = ~sync2_reg & prev_reg & fall_en_reg;
  assign w1c_mask = (wr && adr == A_STATUS) ? (wdata & wmask) : '0;
  // Sets are OR'd in after the clear so a same-cycle set wins.
  assign status_next = (status_reg & ~w1c_mask) | rise | fall;

  // Read mux uses pre-write values, so a STATUS access returns the
  // pre-clear flags.
  always_comb begin
    rdata = '0;
    case (adr)
      A_IN:      rdata[GPIO_WIDTH-1:0] = sync2_reg;
      A_OUT:     rdata[GPIO_WIDTH-1:0] = out_reg;
      A_DIR:     rdata[GPIO_WIDTH-1:0] = dir_reg;
      A_RISE_EN: rdata[GPIO_WIDTH-1:0] = rise_en_reg;
      A_FALL_EN: rdata[GPIO_WIDTH-1:0] = fall_en_reg;
      A_STATUS:  rdata[GPIO_WIDTH-1:0] = status_reg;
      A_IRQ_EN:  rdata[GPIO_WIDTH-1:0] = irq_en_reg;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg   <= S_IDLE;
      ack_reg     <= 1'b0;
      dat_reg     <= '0;
      irq_reg     <= 1'b0;
      out_reg     <= RESET_OUT[GPIO_WIDTH-1:0];
      dir_reg     <= RESET_DIR[GPIO_WIDTH-1:0];
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      status_reg  <= '0;
      irq_en_reg  <= '0;
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      prev_reg    <= '0;
    end else begin
      sync1_reg  <= gpio_i;
      sync2_reg  <= sync1_reg;
      prev_reg   <= sync2_reg;
      status_reg <= status_next;
      irq_reg    <= |(status_reg & irq_en_reg);

      state_reg <= req ? S_ACK : S_IDLE;
      ack_reg   <= req;
      dat_reg   <= (req && !wb_we_i) ? rdata : '0;

      if (wr) begin
        case (adr)
          A_OUT:     out_reg     <= merge(out_reg, wdata, wmask);
          A_DIR:     dir_reg     <= merge(dir_reg, wdata, wmask);
          A_RISE_EN: rise_en_reg <= merge(rise_en_reg, wdata, wmask);
          A_FALL_EN: fall_en_reg <= merge(fall_en_reg, wdata, wmask);
          A_IRQ_EN:  irq_en_reg  <= merge(irq_en_reg, wdata, wmask);
          default:   ;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;
  assign gpio_o   = out_reg;
  assign gpio_oe  = dir_reg;
  assign irq_o    = irq_reg;

  // Address bits [1:0] and data/mask bits above GPIO_WIDTH are ignored.
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, byte_mask};

endmodule

// File: tb/tb_gpio_wb_responder.sv
// tb_gpio_wb_responder
//   Directed plus randomized checks of gpio_wb_responder (8 pins,
//   RESET_DIR=8'h0F, RESET_OUT=8'hA5) against a register-level model.
module tb_gpio_wb_responder;

  logic        clock = 1'b0;
  logic        resetn;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;
  logic        irq_o;

  gpio_wb_responder #(
    .GPIO_WIDTH(8),
    .RESET_DIR (32'h0F),
    .RESET_OUT (32'hA5)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_we_i (wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq_o   (irq_o)
  );

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents indexed by word offset, plus pins.
  logic [7:0] m_reg [0:7];
  logic [7:0] m_pin;

  logic [31:0] rd;
  logic [7:0]  ack_gpio_o;
  logic        ack_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of a register write: only byte lane 0 exists for 8 pins.
  task automatic model_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int idx;
    idx = int'(adr[4:2]);
    if (sel[0]) begin
      if (idx == 5) m_reg[5] = m_reg[5] & ~dat[7:0];
      else if (idx >= 1 && idx <= 6) m_reg[idx] = dat[7:0];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] adr);
    int idx;
    idx = int'(adr[4:2]);
    if (idx == 0) return {24'd0, m_pin};
    if (idx == 7) return 32'd0;
    return {24'd0, m_reg[idx]};
  endfunction

  // Pin change after long stability: flags set where enabled.
  task automatic model_pins(input logic [7:0] new_pin);
    m_reg[5] = m_reg[5] | (new_pin & ~m_pin & m_reg[3]) | (~new_pin & m_pin & m_reg[4]);
    m_pin = new_pin;
  endtask

  // One Wishbone transfer; ack is required on the first edge and must be
  // gone on the next, so this never waits unboundedly.
  task automatic bus(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdata);
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge clock); #1;
    chk("ack_high", {31'd0, wb_ack_o}, 32'd1);
    rdata      = wb_dat_o;
    ack_gpio_o = gpio_o;
    ack_irq    = irq_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clock); #1;
    chk("ack_low", {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    bus(1'b1, adr, dat, sel, dummy);
    model_write(adr, dat, sel);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] adr);
    logic [31:0] v;
    bus(1'b0, adr, 32'd0, 4'hF, v);
    chk(tag, v, model_read(adr));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  a;

    resetn = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; gpio_i = 8'h00;
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_reg[1] = 8'hA5; m_reg[2] = 8'h0F; m_pin = 8'h00;
    ticks(3);
    resetn = 1'b1;

    // Reset values
    chk("rst_oe",  {24'd0, gpio_oe}, 32'h0F);
    chk("rst_out", {24'd0, gpio_o}, 32'hA5);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    rd_chk("rst_status", 5'h14);

    // Byte-lane write, visible at the ack cycle
    wr(5'h04, 32'h0000_00FF, 4'hF);
    chk("out_ff", {24'd0, gpio_o}, 32'hFF);
    wr(5'h04, 32'h0000_3C5A, 4'b0001);
    chk("out_lane_ack", {24'd0, ack_gpio_o}, 32'h5A);
    rd_chk("out_readback", 5'h04);
    wr(5'h04, 32'h0000_7700, 4'b0010);
    chk("out_lane_unsel", {24'd0, gpio_o}, 32'h5A);

    // Input sync: request sampled one edge after the pin change sees 0
    wr(5'h08, 32'hF0, 4'hF);
    chk("dir_oe", {24'd0, gpio_oe}, 32'hF0);
    gpio_i = 8'h81;
    bus(1'b0, 5'h00, 32'd0, 4'hF, r);
    chk("in_early", r, 32'h0);
    model_pins(8'h81);
    rd_chk("in_late", 5'h00);

    // Edge interrupt on pin0
    gpio_i = 8'h80; ticks(4); model_pins(8'h80);
    wr(5'h0C, 32'h01, 4'hF);
    wr(5'h18, 32'h01, 4'hF);
    gpio_i = 8'h81;
    for (int k = 1; k <= 4; k++) begin
      ticks(1);
      chk($sformatf("irq_edge%0d", k), {31'd0, irq_o}, (k == 4) ? 32'd1 : 32'd0);
    end
    model_pins(8'h81);
    rd_chk("status_rise", 5'h14);
    wr(5'h14, 32'h01, 4'h1);
    chk("irq_at_w1c", {31'd0, ack_irq}, 32'd1);
    chk("irq_cleared", {31'd0, irq_o}, 32'd0);
    rd_chk("status_cleared", 5'h14);

    // Simultaneous set and clear on pin2
    wr(5'h10, 32'h04, 4'hF);
    gpio_i = 8'h85; ticks(4); model_pins(8'h85);
    gpio_i = 8'h81;
    ticks(2);
    bus(1'b1, 5'h14, 32'h04, 4'h1, r);
    model_pins(8'h81);
    rd_chk("status_set_wins", 5'h14);
    wr(5'h14, 32'h04, 4'h1);
    rd_chk("status_w1c2", 5'h14);

    // Back-to-back on unmapped offset with strobe held
    wb_we_i = 1'b1; wb_adr_i = 5'h1C; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) ticks(1);
      chk($sformatf("b2b_ack%0d", k), {31'd0, wb_ack_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_dat%0d", k), wb_dat_o, 32'd0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    ticks(1);
    rd_chk("unmapped_rd", 5'h1C);
    for (int i = 1; i <= 6; i++) begin
      a = 5'(i * 4);
      rd_chk($sformatf("unchanged_%0d", i), a);
    end

    // Strobe without cycle
    wb_stb_i = 1'b1; wb_cyc_i = 1'b0; wb_adr_i = 5'h04;
    for (int k = 0; k < 3; k++) begin
      ticks(1);
      chk("stb_no_cyc", {31'd0, wb_ack_o}, 32'd0);
    end
    wb_stb_i = 1'b0;

    // Random register traffic
    for (int n = 0; n < 30; n++) begin
      a = 5'($urandom_range(1, 6) * 4);
      r = $urandom;
      wr(a, r, 4'($urandom));
      a = 5'($urandom_range(0, 7) * 4);
      rd_chk($sformatf("rand_rd_%0d", n), a);
      chk("rand_out", {24'd0, gpio_o}, {24'd0, m_reg[1]});
      chk("rand_oe", {24'd0, gpio_oe}, {24'd0, m_reg[2]});
    end

    // Random pin activity
    for (int n = 0; n < 20; n++) begin
      r = $urandom;
      gpio_i = r[7:0];
      ticks(4);
      model_pins(r[7:0]);
      rd_chk($sformatf("rand_in_%0d", n), 5'h00);
      rd_chk($sformatf("rand_status_%0d", n), 5'h14);
      chk($sformatf("rand_irq_%0d", n), {31'd0, irq_o}, {31'd0, |(m_reg[5] & m_reg[6])});
    end

    // Reset sharing an edge with a write strobe drops the write and ack
    wb_we_i = 1'b1; wb_adr_i = 5'h04; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; resetn = 1'b0;
    ticks(1);
    chk("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_mid_out", {24'd0, gpio_o}, 32'hA5);
    chk("rst_mid_irq", {31'd0, irq_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; resetn = 1'b1;
    ticks(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
